seg_sniffer: RTL
================

SEG_SNIFFER -- requirements
Module: seg_sniffer

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of multiplexed digits observed.
REQ-002 SHALL have parameter STABLE_CYC, default 4: cycles a digit select plus pattern must hold unchanged before capture (range 1..255).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port an, input, NDIG: digit select, active-low, one-hot-low when valid.
REQ-006 SHALL have port seg, input, 7: segment pattern, active-low, bit 0 = segment a … bit 6 = segment g.
REQ-007 SHALL have port digits, output, 4*NDIG: decoded frame; nibble i belongs to an[i].
REQ-008 SHALL have port blank, output, NDIG: bit i set when digit i showed 7'b1111111.
REQ-009 SHALL have port err, output, NDIG: bit i set when digit i showed a non-table pattern.
REQ-010 SHALL have port frame_valid, output, 1: one-cycle pulse when digits/blank/err update.
REQ-011 SHALL have port err_cnt, output, 8: saturating invalid-pattern count.

Function
REQ-012 SHALL decode seg as 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F (hex values of seg[6:0]).
REQ-013 SHALL decode 7F as blank: nibble 0, blank bit 1, err bit 0.
REQ-014 SHALL decode any other pattern as invalid: nibble 0, blank bit 0, err bit 1.
REQ-015 SHALL treat an as valid only when exactly one bit is 0; all-ones or multiple-low is invalid.
REQ-016 SHALL run the FSM IDLE → SETTLE → LATCHED.
REQ-017 IDLE: on a valid an, SHALL load the settle counter with 1, record an and seg, and go to SETTLE.
REQ-018 SETTLE: while an and seg equal their recorded values, SHALL increment the counter each cycle.
REQ-019 SETTLE: when the counter reaches STABLE_CYC, SHALL capture the decoded digit into the shadow slot, set its mask bit, and go to LATCHED.
REQ-020 SETTLE: on any an or seg change, SHALL restart from the new value if valid (counter=1), otherwise go to IDLE.
REQ-021 LATCHED: SHALL hold until an or seg changes, then behave as REQ-020; no recapture without a change.
REQ-022 Capture timing: a pattern stable from cycle N SHALL be captured at the clock edge ending cycle N+STABLE_CYC-1.
REQ-023 On recapture of an already-masked slot before frame completion, the shadow slot SHALL be overwritten (latest wins).
REQ-024 When the mask becomes all-ones, on the same edge SHALL copy the shadow into digits/blank/err, pulse frame_valid for exactly one cycle, and clear the mask.
REQ-025 Outputs SHALL change only on frame_valid cycles.

Reset
REQ-026 Asserting rst_n low SHALL immediately (asynchronously) force FSM=IDLE, counter=0, mask=0, shadow=0, digits=0, blank=0, err=0, frame_valid=0, err_cnt=0.
REQ-027 Reset mid-SETTLE or mid-frame SHALL discard partial captures; the first frame_valid after release requires all NDIG digits to be captured anew.

Configuration
REQ-028 With SEG_SNIFFER_ERRCNT_EN defined, err_cnt SHALL increment by 1 per capture of an invalid pattern, saturating at 255, cleared only by reset.
REQ-029 Without SEG_SNIFFER_ERRCNT_EN, err_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-030 Scan an=FE..7F (NDIG=8), seg patterns for digits 1..8, 6 cycles each → one frame_valid, digits=32'h87654321, blank=0, err=0.
REQ-031 Same scan with each digit held only 3 cycles (STABLE_CYC=4) → no frame_valid, digits stay 0.
REQ-032 Digit 3 seg=7F, digit 5 seg=7E, others valid → blank=8'h08, err=8'h20, nibbles 3 and 5 = 0; err_cnt=1 with macro, 0 without.
REQ-033 an=8'hFC (two low) for 10 cycles → no capture; FSM stays IDLE.
REQ-034 Assert rst_n low after 4 digits captured, release, then scan 8 digits → exactly one frame_valid, at the end of the post-reset scan.
REQ-035 Hold invalid seg across 300 captures with macro → err_cnt=255.

Source files
------------

// File: rtl/seg_sniffer.sv
// Passive sniffer for a multiplexed active-low 7-segment display: it rebuilds the shown digits into a frame.
// Optional saturating invalid-pattern counter is enabled with `define SEG_SNIFFER_ERRCNT_EN.
module seg_sniffer #(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   err,
  output logic              frame_valid,
  output logic [7:0]        err_cnt
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ZCW  = $clog2(NDIG + 1);
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, LATCHED} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NDIG-1:0]     an_rec_q, an_rec_d;
  logic [6:0]          seg_rec_q, seg_rec_d;
  logic [NDIG-1:0]     mask_q, mask_d;
  logic [4*NDIG-1:0]   shadow_nib_q, shadow_nib_d;
  logic [NDIG-1:0]     shadow_blank_q, shadow_blank_d;
  logic [NDIG-1:0]     shadow_err_q, shadow_err_d;
  logic [4*NDIG-1:0]   digits_q, digits_d;
  logic [NDIG-1:0]     blank_q, blank_d;
  logic [NDIG-1:0]     err_q, err_d;
  logic                fv_q, fv_d;

  logic [3:0]          dec_nib;
  logic                dec_blank;
  logic                dec_err;
  logic [ZCW-1:0]      an_zeros;
  logic [IDXW-1:0]     sel_idx;
  logic                an_valid;
  logic                changed;
  logic                start;
  logic                capture;

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    unique case (seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // A digit select is only usable when exactly one anode line is driven low.
  always_comb begin
    an_zeros = '0;
    sel_idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an[i]) begin
        an_zeros = an_zeros + ZCW'(1);
        sel_idx  = IDXW'(i);
      end
    end
  end

  assign an_valid = (an_zeros == ZCW'(1));
  assign changed  = (an != an_rec_q) || (seg != seg_rec_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    an_rec_d  = an_rec_q;
    seg_rec_d = seg_rec_q;
    start     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (an_valid) start = 1'b1;
      end
      SETTLE: begin
        if (changed) begin
          if (an_valid) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE_LIM) begin
            capture = 1'b1;
            state_d = LATCHED;
          end
        end
      end
      LATCHED: begin
        if (changed) begin
          if (an_valid) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // The first stable cycle already counts, so a one-cycle threshold captures on entry.
    if (start) begin
      cnt_d     = 8'd1;
      an_rec_d  = an;
      seg_rec_d = seg;
      if (STABLE_LIM == 8'd1) begin
        capture = 1'b1;
        state_d = LATCHED;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  always_comb begin
    shadow_nib_d   = shadow_nib_q;
    shadow_blank_d = shadow_blank_q;
    shadow_err_d   = shadow_err_q;
    mask_d         = mask_q;
    digits_d       = digits_q;
    blank_d        = blank_q;
    err_d          = err_q;
    fv_d           = 1'b0;
    if (capture) begin
      shadow_nib_d[{sel_idx, 2'b00} +: 4] = dec_nib;
      shadow_blank_d[sel_idx]             = dec_blank;
      shadow_err_d[sel_idx]               = dec_err;
      mask_d[sel_idx]                     = 1'b1;
      if (&mask_d) begin
        digits_d = shadow_nib_d;
        blank_d  = shadow_blank_d;
        err_d    = shadow_err_d;
        fv_d     = 1'b1;
        mask_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      an_rec_q       <= '1;
      seg_rec_q      <= 7'h7F;
      mask_q         <= '0;
      shadow_nib_q   <= '0;
      shadow_blank_q <= '0;
      shadow_err_q   <= '0;
      digits_q       <= '0;
      blank_q        <= '0;
      err_q          <= '0;
      fv_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      an_rec_q       <= an_rec_d;
      seg_rec_q      <= seg_rec_d;
      mask_q         <= mask_d;
      shadow_nib_q   <= shadow_nib_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_err_q   <= shadow_err_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      err_q          <= err_d;
      fv_q           <= fv_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = fv_q;

`ifdef SEG_SNIFFER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (capture && dec_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
